// File: rtl/host_mem_responder_if.sv
// Host memory channel bundle: c0 read request/response, c1 write request/ack.
// The master modport is the host, which issues requests; the slave modport is the responder.
interface host_mem_responder_if;
  logic         c0tx_valid;
  logic [41:0]  c0tx_addr;
  logic [15:0]  c0tx_mdata;
  logic         c0tx_almfull;
  logic         c1tx_valid;
  logic [41:0]  c1tx_addr;
  logic [511:0] c1tx_data;
  logic         c0rx_valid;
  logic [511:0] c0rx_data;
  logic [15:0]  c0rx_mdata;
  logic         c1rx_valid;

  modport master (
    output c0tx_valid, c0tx_addr, c0tx_mdata, c1tx_valid, c1tx_addr, c1tx_data,
    input  c0tx_almfull, c0rx_valid, c0rx_data, c0rx_mdata, c1rx_valid
  );

  modport slave (
    input  c0tx_valid, c0tx_addr, c0tx_mdata, c1tx_valid, c1tx_addr, c1tx_data,
    output c0tx_almfull, c0rx_valid, c0rx_data, c0rx_mdata, c1rx_valid
  );
endinterface

// File: rtl/host_mem_responder.sv
// Host memory responder: line memory with read queue, fixed-latency read pipeline, write acks.
// Optional macro HOST_MEM_RSP_ALMFULL_EN enables the registered read-queue almost-full flag.
module host_mem_responder #(
  parameter int unsigned IDX_BITS       = 4,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned RDQ_DEPTH      = 8,
  parameter int unsigned ALMFULL_THRESH = 6
) (
  input  logic                clk,
  input  logic                reset,
  host_mem_responder_if.slave bus,
  input  logic                ld_en,
  input  logic [IDX_BITS-1:0] ld_idx,
  input  logic [511:0]        ld_data,
  output logic                err_oob,
  output logic                err_ovf,
  output logic [15:0]         rd_cnt,
  output logic [15:0]         wr_cnt
);

  localparam int unsigned ADDR_W = 42;
  localparam int unsigned LINE_W = 512;
  localparam int unsigned TAG_W  = 16;
  localparam int unsigned LINES  = 1 << IDX_BITS;
  localparam int unsigned QW     = $clog2(RDQ_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  mdata;
  } rdq_entry_t;

  logic [LINE_W-1:0] mem [LINES];
  rdq_entry_t        rdq [RDQ_DEPTH];

  logic [QW:0]           wr_ptr;
  logic [QW:0]           rd_ptr;
  logic [QW:0]           occupancy;
  logic                  q_full;
  logic                  pop;
  logic                  push;
  logic                  ovf;
  rdq_entry_t            head;
  logic [IDX_BITS-1:0]   head_idx;
  logic                  head_inwin;
  logic [IDX_BITS-1:0]   wr_idx;
  logic                  wr_inwin;
  logic                  wr_en;
  logic [LINE_W-1:0]     pop_line;
  logic [RD_LATENCY-1:0] st_valid;
  logic [LINE_W-1:0]     st_data  [RD_LATENCY];
  logic [TAG_W-1:0]      st_mdata [RD_LATENCY];
  logic                  ack_q;

  // Queue bookkeeping; the head drains every cycle the queue holds anything.
  assign occupancy = wr_ptr - rd_ptr;
  assign q_full    = (occupancy == (QW+1)'(RDQ_DEPTH));
  assign pop       = (occupancy != '0);
  assign push      = bus.c0tx_valid && (!q_full || pop);
  assign ovf       = bus.c0tx_valid && q_full && !pop;

  assign head       = rdq[rd_ptr[QW-1:0]];
  assign head_idx   = head.addr[IDX_BITS-1:0];
  assign head_inwin = (head.addr[ADDR_W-1:IDX_BITS] == '0);
  assign wr_idx     = bus.c1tx_addr[IDX_BITS-1:0];
  assign wr_inwin   = (bus.c1tx_addr[ADDR_W-1:IDX_BITS] == '0);
  assign wr_en      = bus.c1tx_valid && wr_inwin;

  // Line sampled at pop; same-cycle writes are forwarded so the read sees them.
  always_comb begin
    pop_line = '0;
    if (head_inwin) begin
      if (wr_en && (wr_idx == head_idx)) begin
        pop_line = bus.c1tx_data;
      end else if (ld_en && (ld_idx == head_idx)) begin
        pop_line = ld_data;
      end else begin
        pop_line = mem[head_idx];
      end
    end
  end

  // Storage is not reset; c1tx is written last so it wins over a same-index preload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ld_en) mem[ld_idx] <= ld_data;
      if (wr_en) mem[wr_idx] <= bus.c1tx_data;
      if (push)  rdq[wr_ptr[QW-1:0]] <= {bus.c0tx_addr, bus.c0tx_mdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      st_valid <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        st_data[i]  <= '0;
        st_mdata[i] <= '0;
      end
      ack_q   <= 1'b0;
      err_oob <= 1'b0;
      err_ovf <= 1'b0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (QW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (QW+1)'(1);

      // Data and tag stay zero in empty stages so idle outputs read as zero.
      st_valid[0] <= pop;
      st_data[0]  <= pop ? pop_line : '0;
      st_mdata[0] <= pop ? head.mdata : '0;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        st_valid[i] <= st_valid[i-1];
        st_data[i]  <= st_data[i-1];
        st_mdata[i] <= st_mdata[i-1];
      end

      ack_q <= bus.c1tx_valid;

      if ((bus.c1tx_valid && !wr_inwin) || (pop && !head_inwin)) err_oob <= 1'b1;
      if (ovf) err_ovf <= 1'b1;

      if (st_valid[RD_LATENCY-1] && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
      if (ack_q && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
    end
  end

  assign bus.c0rx_valid = st_valid[RD_LATENCY-1];
  assign bus.c0rx_data  = st_data[RD_LATENCY-1];
  assign bus.c0rx_mdata = st_mdata[RD_LATENCY-1];
  assign bus.c1rx_valid = ack_q;

`ifdef HOST_MEM_RSP_ALMFULL_EN
  logic almfull_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      almfull_q <= 1'b0;
    end else begin
      almfull_q <= (occupancy >= (QW+1)'(ALMFULL_THRESH));
    end
  end

  assign bus.c0tx_almfull = almfull_q;
`else
  assign bus.c0tx_almfull = 1'b0;
`endif

endmodule
